// File: rtl/usb_ls_bus_model.sv
// usb_ls_bus_model
// Simulation model of NUM_PORTS low-speed USB cables between host ports and
// device models. Each port has independent attach debouncing, an optional
// DELAY-stage cable pipeline in each direction, pull-up/pull-down line
// resolution, and sticky conflict detection with a saturating episode counter.
module usb_ls_bus_model #(
    parameter int NUM_PORTS  = 2,
    parameter int DELAY      = 0,
    parameter int ATTACH_DLY = 16,
    parameter int CNT_W      = 8
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic [NUM_PORTS-1:0]       host_dp_o,
    input  logic [NUM_PORTS-1:0]       host_dm_o,
    input  logic [NUM_PORTS-1:0]       host_oe,
    output logic [NUM_PORTS-1:0]       host_dp_i,
    output logic [NUM_PORTS-1:0]       host_dm_i,
    input  logic [NUM_PORTS-1:0]       dev_dp_o,
    input  logic [NUM_PORTS-1:0]       dev_dm_o,
    input  logic [NUM_PORTS-1:0]       dev_oe,
    output logic [NUM_PORTS-1:0]       dev_dp_i,
    output logic [NUM_PORTS-1:0]       dev_dm_i,
    input  logic [NUM_PORTS-1:0]       attach,
    output logic [NUM_PORTS-1:0]       connected,
    input  logic [NUM_PORTS-1:0]       conflict_clr,
    output logic [NUM_PORTS-1:0]       conflict,
    output logic [NUM_PORTS*CNT_W-1:0] conflict_cnt
);

    localparam int AW = $clog2(ATTACH_DLY + 1);
    localparam logic [NUM_PORTS-1:0] ZERO_P = {NUM_PORTS{1'b0}};
    localparam logic [NUM_PORTS-1:0] ONES_P = {NUM_PORTS{1'b1}};
    localparam logic [AW-1:0]        ZERO_A = {AW{1'b0}};
    localparam logic [AW-1:0]        ONE_A  = AW'(1);
    localparam logic [AW-1:0]        LAST_A = AW'(ATTACH_DLY - 1);
    localparam logic [CNT_W-1:0]     ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0]     MAX_C  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_DETACHED  = 2'd0,
        ST_COUNTING  = 2'd1,
        ST_CONNECTED = 2'd2
    } att_state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == MAX_C) begin
            r = v;
        end else begin
            r = v + ONE_C;
        end
        return r;
    endfunction

    // Delayed copies of both sides' drives; everything downstream uses these.
    logic [NUM_PORTS-1:0] h_oe_d_s, h_dp_d_s, h_dm_d_s;
    logic [NUM_PORTS-1:0] d_oe_d_s, d_dp_d_s, d_dm_d_s;

    generate
        if (DELAY == 0) begin : g_nodly
            assign h_oe_d_s = host_oe;
            assign h_dp_d_s = host_dp_o;
            assign h_dm_d_s = host_dm_o;
            assign d_oe_d_s = dev_oe;
            assign d_dp_d_s = dev_dp_o;
            assign d_dm_d_s = dev_dm_o;
        end else begin : g_dly
            logic [NUM_PORTS-1:0] h_oe_r [DELAY];
            logic [NUM_PORTS-1:0] h_dp_r [DELAY];
            logic [NUM_PORTS-1:0] h_dm_r [DELAY];
            logic [NUM_PORTS-1:0] d_oe_r [DELAY];
            logic [NUM_PORTS-1:0] d_dp_r [DELAY];
            logic [NUM_PORTS-1:0] d_dm_r [DELAY];

            // Cable pipeline: shifts every cycle, resets to an idle undriven J line.
            always_ff @(posedge clk or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DELAY; i++) begin
                        h_oe_r[i] <= ZERO_P;
                        h_dp_r[i] <= ZERO_P;
                        h_dm_r[i] <= ONES_P;
                        d_oe_r[i] <= ZERO_P;
                        d_dp_r[i] <= ZERO_P;
                        d_dm_r[i] <= ONES_P;
                    end
                end else begin
                    h_oe_r[0] <= host_oe;
                    h_dp_r[0] <= host_dp_o;
                    h_dm_r[0] <= host_dm_o;
                    d_oe_r[0] <= dev_oe;
                    d_dp_r[0] <= dev_dp_o;
                    d_dm_r[0] <= dev_dm_o;
                    for (int i = 1; i < DELAY; i++) begin
                        h_oe_r[i] <= h_oe_r[i-1];
                        h_dp_r[i] <= h_dp_r[i-1];
                        h_dm_r[i] <= h_dm_r[i-1];
                        d_oe_r[i] <= d_oe_r[i-1];
                        d_dp_r[i] <= d_dp_r[i-1];
                        d_dm_r[i] <= d_dm_r[i-1];
                    end
                end
            end

            assign h_oe_d_s = h_oe_r[DELAY-1];
            assign h_dp_d_s = h_dp_r[DELAY-1];
            assign h_dm_d_s = h_dm_r[DELAY-1];
            assign d_oe_d_s = d_oe_r[DELAY-1];
            assign d_dp_d_s = d_dp_r[DELAY-1];
            assign d_dm_d_s = d_dm_r[DELAY-1];
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            att_state_e       state_r;
            logic [AW-1:0]    att_cnt_r;
            logic             conn_r;
            logic             event_prev_r;
            logic             conf_r;
            logic [CNT_W-1:0] conf_cnt_r;
            logic             event_s;
            logic             start_s;

            // Attach debounce: attach must be seen on ATTACH_DLY edges in a row.
            always_ff @(posedge clk or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_r   <= ST_DETACHED;
                    att_cnt_r <= ZERO_A;
                    conn_r    <= 1'b0;
                end else if (!attach[p]) begin
                    state_r   <= ST_DETACHED;
                    att_cnt_r <= ZERO_A;
                    conn_r    <= 1'b0;
                end else begin
                    case (state_r)
                        ST_DETACHED: begin
                            if (LAST_A == ZERO_A) begin
                                state_r <= ST_CONNECTED;
                                conn_r  <= 1'b1;
                            end else begin
                                state_r   <= ST_COUNTING;
                                att_cnt_r <= ONE_A;
                            end
                        end
                        ST_COUNTING: begin
                            if (att_cnt_r == LAST_A) begin
                                state_r <= ST_CONNECTED;
                                conn_r  <= 1'b1;
                            end else begin
                                att_cnt_r <= att_cnt_r + ONE_A;
                            end
                        end
                        ST_CONNECTED: begin
                            conn_r <= 1'b1;
                        end
                        default: begin
                            state_r   <= ST_DETACHED;
                            att_cnt_r <= ZERO_A;
                            conn_r    <= 1'b0;
                        end
                    endcase
                end
            end

            assign event_s = conn_r & h_oe_d_s[p] & d_oe_d_s[p];
            assign start_s = event_s & ~event_prev_r;

            // Conflict episodes: count rising edges of the overlap; a clear
            // landing on a new episode leaves exactly that episode recorded.
            always_ff @(posedge clk or negedge rst_ni) begin
                if (!rst_ni) begin
                    event_prev_r <= 1'b0;
                    conf_r       <= 1'b0;
                    conf_cnt_r   <= ZERO_C;
                end else begin
                    event_prev_r <= event_s;
                    if (start_s) begin
                        conf_r     <= 1'b1;
                        conf_cnt_r <= conflict_clr[p] ? ONE_C : sat_inc(conf_cnt_r);
                    end else if (conflict_clr[p]) begin
                        conf_r     <= 1'b0;
                        conf_cnt_r <= ZERO_C;
                    end
                end
            end

            // Line resolution: pull-downs when unplugged, J when nobody drives.
            always_comb begin
                host_dp_i[p] = 1'b0;
                host_dm_i[p] = 1'b0;
                dev_dp_i[p]  = 1'b0;
                dev_dm_i[p]  = 1'b1;
                if (conn_r) begin
                    if (d_oe_d_s[p]) begin
                        host_dp_i[p] = d_dp_d_s[p];
                        host_dm_i[p] = d_dm_d_s[p];
                    end else begin
                        host_dp_i[p] = 1'b0;
                        host_dm_i[p] = 1'b1;
                    end
                    if (h_oe_d_s[p]) begin
                        dev_dp_i[p] = h_dp_d_s[p];
                        dev_dm_i[p] = h_dm_d_s[p];
                    end else begin
                        dev_dp_i[p] = 1'b0;
                        dev_dm_i[p] = 1'b1;
                    end
                end else begin
                    host_dp_i[p] = 1'b0;
                    host_dm_i[p] = 1'b0;
                    dev_dp_i[p]  = 1'b0;
                    dev_dm_i[p]  = 1'b1;
                end
            end

            assign connected[p]                    = conn_r;
            assign conflict[p]                     = conf_r;
            assign conflict_cnt[p*CNT_W +: CNT_W]  = conf_cnt_r;
        end
    endgenerate

endmodule
